jump_game_ctrl: RTL and testbench
=================================

# jump_game_ctrl

Parametrised game controller for the jump game. It keeps a queue of `NUM_BLOCKS` visible platforms, sequences title, reload, charge, jump, landing and game-over, and drives the jump engine through an enable/done handshake. It scores landings, with a bonus for centre hits, and feeds graphics with man, block, type, title and game-over data. It sits between the button/random sources, the jump engine and the graphics block.

## Interface
- `XW`, 11: x-coordinate width.
- `NUM_BLOCKS`, 3: platform slots, ≥2.
- `NUM_TYPES`, 6: block picture types; type field is 5 bits.
- `HALF_WIDTH`, 30: landing tolerance.
- `CENTER_TOL`, 5: centre-hit tolerance.
- `MIN_GAP`, 65: minimum slot spacing.
- `RAND_W`, 7: random input width.
- `ACC_W`, 24: charge accumulator width.
- `VW`, 7: initial-velocity width.
- `RELOAD_DIV`, 17: scroll prescaler width (one step per 2^RELOAD_DIV cycles).
- `SCORE_W`, 16: score width.
- `ORIGIN_STARTUP`, 100: slot-0 x after reset.

Ports:
- `clk_machine` in 1: single clock.
- `rst_machine` in 1: synchronous, active-high reset.
- `i_btn` in 1: player button, already synchronous and debounced.
- `i_random` in RAND_W: free-running random value.
- `i_jump_done` in 1: jump engine finished.
- `i_jump_dist` in XW: horizontal offset from takeoff.
- `i_jump_height` in 9: vertical offset.
- `o_jump_en` out 1: jump engine enable.
- `o_jump_v_init` out VW: initial velocity.
- `o_squeeze_man` out 4: man squeeze frame, 0–14.
- `o_state` out 3: state code.
- `o_x_man` out XW, `o_y_man` out 9: man position.
- `o_x_block` out NUM_BLOCKS*XW: packed slot x values, slot 0 in the LSBs.
- `o_type_index` out NUM_BLOCKS*5: packed slot types.
- `o_en_block` out NUM_BLOCKS: slot visible.
- `o_score` out SCORE_W: score.
- `o_title` out 1: show title screen.
- `o_gameover` out 1: show game-over screen.

## Operation
- **State codes:** TITLE=0, RELD=1, WAIT=2, ACCU=3, JUMP=4, LAND=5, SHIFT=6, OVER=7.
- **Reset values:**
  - State TITLE; `o_title`=1; `o_gameover`=0; score 0; accumulator 0; `o_jump_en`=0; prescaler 0.
  - Slot 0: x=ORIGIN_STARTUP, type 0, enabled. Other slots: x=0, type k mod NUM_TYPES, disabled.
  - Man: x=ORIGIN_STARTUP, y=0.
- **TITLE:** a button rising edge moves to RELD; `o_title` drops on that transition.
- **RELD, scroll phase:** while slot-0 x>0, every enabled slot's x decrements by 1 on each prescaler wrap. Man x tracks slot 0.
- **RELD, fill phase:** once slot-0 x=0, fill the lowest disabled slot k, one slot per cycle:
  - x(k) = x(k−1) + MIN_GAP + `i_random`, saturating at 2^XW−1.
  - Set enable(k).
  - When all slots are enabled, go to WAIT.
- **WAIT:** `i_btn`=1 moves to ACCU.
- **ACCU:**
  - While `i_btn`=1, the accumulator increments, saturating at all-ones.
  - On `i_btn`=0, go to JUMP.
  - `o_jump_v_init` = acc[ACC_W−1 -: VW].
  - `o_squeeze_man` = min(acc[ACC_W−1 -: 4], 14).
- **JUMP:**
  - `o_jump_en`=1 throughout.
  - Man x = slot-0 x + `i_jump_dist` (XW-bit wrap); man y = `i_jump_height`.
  - On `i_jump_done`, go to LAND; `o_jump_en` and the accumulator clear on the same edge.
- **LAND** (one cycle; d0=|man x − slot-0 x|, d1=|man x − slot-1 x|):
  - d0≤HALF_WIDTH → WAIT, no score.
  - Otherwise d1≤HALF_WIDTH → SHIFT; score +2 if d1≤CENTER_TOL, else +1; score saturates.
  - Otherwise → OVER.
  - d0 is checked first.
- **SHIFT** (one cycle):
  - Slot k takes slot k+1 (x, type, enable).
  - Top slot: disabled; type = (previous top type + 1) mod NUM_TYPES.
  - Man x = new slot-0 x; y=0.
  - Next state RELD.
- **OVER:** `o_gameover`=1. A button rising edge clears score and gameover, restores the reset geometry, and goes to TITLE.

## Timing
- All outputs are registered and change on the `clk_machine` edge after the causing input.
- `o_jump_en` rises on the edge entering JUMP.
- `i_jump_done` is sampled only in JUMP; it is ignored elsewhere.
- Button edge detection uses one internal delay register.
- A button already high when TITLE or OVER is entered does not count as a press.
- Reset has priority over every state, including mid-jump: all outputs return to reset values on the next edge.
- Fill takes NUM_BLOCKS−1 cycles after scroll completes.
- If slot-0 x is already 0 on entering RELD, fill starts in the first RELD cycle.

## Configuration
- `JUMP_COMBO_EN`:
  - Defined: an internal combo counter (4 bits, saturating at 15) increments on each centre hit and clears on a non-centre landing or on OVER. A centre hit adds 2×combo, using the combo value after incrementing.
  - Undefined: a centre hit adds a fixed 2 and no combo logic is built.

## Structure
- Package `jump_game_pkg` holds:
  - the state enum/codes;
  - default parameter constants;
  - the type-field width (5).
- Sub-module `jump_block_queue` holds the slot x/type/enable registers with scroll, fill and shift commands. The controller owns the FSM, accumulator, scoring and man position.

## Test plan
- Reset, then press the button → `o_title` 1→0; slot-0 x goes 100→0 in 100×2^RELOAD_DIV cycles. With `i_random`=10, slot 1 x=75 and slot 2 x=150; state reaches WAIT.
- Hold the button 2^17 cycles, then release → `o_jump_v_init`=1, `o_jump_en`=1 until `i_jump_done`, then LAND.
- From slot 0=0, slot 1=75: dist=75 → score +2, then SHIFT. dist=100 → score +1. dist=20 → WAIT, score unchanged. dist=200 → OVER, `o_gameover`=1.
- Hold the button past saturation → accumulator stops at all-ones, `o_jump_v_init`=127, `o_squeeze_man`=14.
- Assert `rst_machine` mid-JUMP → `o_jump_en`=0, state TITLE, score 0, slot-0 x=100 on the next edge.
- With `JUMP_COMBO_EN`, three consecutive centre hits → score 2, 6, 12.

Source files
------------

// File: rtl/jump_game_pkg.sv
// State codes, type-field width and default parameters for the jump game controller.
package jump_game_pkg;

    localparam int TYPE_W             = 5;

    localparam int DEF_XW             = 11;
    localparam int DEF_NUM_BLOCKS     = 3;
    localparam int DEF_NUM_TYPES      = 6;
    localparam int DEF_HALF_WIDTH     = 30;
    localparam int DEF_CENTER_TOL     = 5;
    localparam int DEF_MIN_GAP        = 65;
    localparam int DEF_RAND_W         = 7;
    localparam int DEF_ACC_W          = 24;
    localparam int DEF_VW             = 7;
    localparam int DEF_RELOAD_DIV     = 17;
    localparam int DEF_SCORE_W        = 16;
    localparam int DEF_ORIGIN_STARTUP = 100;

    typedef enum logic [2:0] {
        ST_TITLE = 3'd0,
        ST_RELD  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ACCU  = 3'd3,
        ST_JUMP  = 3'd4,
        ST_LAND  = 3'd5,
        ST_SHIFT = 3'd6,
        ST_OVER  = 3'd7
    } state_t;

endpackage

// File: rtl/jump_game_ctrl_if.sv
// Enable/done handshake between the game controller (master) and the jump engine (slave).
interface jump_game_ctrl_if
    import jump_game_pkg::*;
#(
    parameter int XW = DEF_XW,
    parameter int VW = DEF_VW
);
    logic          o_jump_en;
    logic [VW-1:0] o_jump_v_init;
    logic          i_jump_done;
    logic [XW-1:0] i_jump_dist;
    logic [8:0]    i_jump_height;

    modport master (
        output o_jump_en, o_jump_v_init,
        input  i_jump_done, i_jump_dist, i_jump_height
    );

    modport slave (
        input  o_jump_en, o_jump_v_init,
        output i_jump_done, i_jump_dist, i_jump_height
    );
endinterface

// File: rtl/jump_block_queue.sv
// Platform slot registers (x, type, enable) with scroll, fill and shift commands.
module jump_block_queue
    import jump_game_pkg::*;
#(
    parameter int XW             = DEF_XW,
    parameter int NUM_BLOCKS     = DEF_NUM_BLOCKS,
    parameter int NUM_TYPES      = DEF_NUM_TYPES,
    parameter int MIN_GAP        = DEF_MIN_GAP,
    parameter int RAND_W         = DEF_RAND_W,
    parameter int ORIGIN_STARTUP = DEF_ORIGIN_STARTUP
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         init,
    input  logic                         scroll,
    input  logic                         fill,
    input  logic                         shift,
    input  logic [RAND_W-1:0]            random,
    output logic [NUM_BLOCKS*XW-1:0]     x_block,
    output logic [NUM_BLOCKS*TYPE_W-1:0] type_index,
    output logic [NUM_BLOCKS-1:0]        en_block,
    output logic [XW-1:0]                x0,
    output logic [XW-1:0]                x1,
    output logic                         all_en,
    output logic                         fill_last
);
    localparam int IDX_W = $clog2(NUM_BLOCKS);

    logic [XW-1:0]         x_q [NUM_BLOCKS];
    logic [TYPE_W-1:0]     t_q [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0] en_q;

    logic [IDX_W-1:0]      free_idx;
    logic [XW-1:0]         prev_x;
    logic [XW+1:0]         fill_sum;
    logic [XW-1:0]         fill_x;

    // Descending scan so the lowest disabled slot wins; slot 0 is never the fill target.
    always_comb begin
        free_idx = '0;
        prev_x   = x_q[0];
        for (int k = NUM_BLOCKS - 1; k >= 1; k--) begin
            if (!en_q[k]) begin
                free_idx = IDX_W'(k);
                prev_x   = x_q[k-1];
            end
        end
    end

    assign fill_sum  = {2'b00, prev_x} + (XW+2)'(MIN_GAP) + (XW+2)'(random);
    assign fill_x    = (fill_sum[XW+1:XW] != 2'b00) ? '1 : fill_sum[XW-1:0];
    assign all_en    = &en_q;
    assign fill_last = !all_en && (free_idx == IDX_W'(NUM_BLOCKS - 1));

    always_ff @(posedge clk) begin
        if (rst || init) begin
            for (int k = 0; k < NUM_BLOCKS; k++) begin
                x_q[k] <= (k == 0) ? XW'(ORIGIN_STARTUP) : '0;
                t_q[k] <= TYPE_W'(k % NUM_TYPES);
            end
            en_q <= NUM_BLOCKS'(1);
        end else if (shift) begin
            for (int k = 0; k < NUM_BLOCKS - 1; k++) begin
                x_q[k] <= x_q[k+1];
                t_q[k] <= t_q[k+1];
            end
            t_q[NUM_BLOCKS-1] <= (t_q[NUM_BLOCKS-1] == TYPE_W'(NUM_TYPES - 1)) ?
                                 '0 : t_q[NUM_BLOCKS-1] + TYPE_W'(1);
            en_q <= {1'b0, en_q[NUM_BLOCKS-1:1]};
        end else if (fill && !all_en) begin
            x_q[free_idx]  <= fill_x;
            en_q[free_idx] <= 1'b1;
        end else if (scroll) begin
            for (int k = 0; k < NUM_BLOCKS; k++) begin
                if (en_q[k] && (x_q[k] != '0))
                    x_q[k] <= x_q[k] - XW'(1);
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_BLOCKS; k++) begin
            x_block[k*XW +: XW]             = x_q[k];
            type_index[k*TYPE_W +: TYPE_W]  = t_q[k];
        end
    end

    assign en_block = en_q;
    assign x0       = x_q[0];
    assign x1       = x_q[1];

endmodule

// File: rtl/jump_game_ctrl.sv
// Jump game controller: FSM, charge accumulator, scoring and man position around the slot queue.
// Build option JUMP_COMBO_EN adds a centre-hit combo multiplier to the score.
//
// state | meaning
// TITLE | title screen, wait for button press
// RELD  | scroll slot 0 to x=0, then fill empty slots
// WAIT  | idle on platform, button starts charging
// ACCU  | charging while button held
// JUMP  | jump engine running
// LAND  | classify landing, score
// SHIFT | advance the slot queue by one
// OVER  | game-over screen, button returns to title
module jump_game_ctrl
    import jump_game_pkg::*;
#(
    parameter int XW             = DEF_XW,
    parameter int NUM_BLOCKS     = DEF_NUM_BLOCKS,
    parameter int NUM_TYPES      = DEF_NUM_TYPES,
    parameter int HALF_WIDTH     = DEF_HALF_WIDTH,
    parameter int CENTER_TOL     = DEF_CENTER_TOL,
    parameter int MIN_GAP        = DEF_MIN_GAP,
    parameter int RAND_W         = DEF_RAND_W,
    parameter int ACC_W          = DEF_ACC_W,
    parameter int VW             = DEF_VW,
    parameter int RELOAD_DIV     = DEF_RELOAD_DIV,
    parameter int SCORE_W        = DEF_SCORE_W,
    parameter int ORIGIN_STARTUP = DEF_ORIGIN_STARTUP
) (
    input  logic                         clk_machine,
    input  logic                         rst_machine,
    input  logic                         i_btn,
    input  logic [RAND_W-1:0]            i_random,
    jump_game_ctrl_if.master             jmp,
    output logic [3:0]                   o_squeeze_man,
    output logic [2:0]                   o_state,
    output logic [XW-1:0]                o_x_man,
    output logic [8:0]                   o_y_man,
    output logic [NUM_BLOCKS*XW-1:0]     o_x_block,
    output logic [NUM_BLOCKS*TYPE_W-1:0] o_type_index,
    output logic [NUM_BLOCKS-1:0]        o_en_block,
    output logic [SCORE_W-1:0]           o_score,
    output logic                         o_title,
    output logic                         o_gameover
);
    state_t                state;
    logic                  btn_d;
    logic                  press;
    logic [RELOAD_DIV-1:0] presc;
    logic [ACC_W-1:0]      acc;
    logic [ACC_W-1:0]      acc_nxt;

    logic                  q_init;
    logic                  q_scroll;
    logic                  q_fill;
    logic                  q_shift;
    logic [XW-1:0]         x0;
    logic [XW-1:0]         x1;
    logic                  all_en;
    logic                  fill_last;

    logic [XW-1:0]         d0;
    logic [XW-1:0]         d1;
    logic                  centre;
    logic [4:0]            hit_pts;
    logic [SCORE_W:0]      score_sum;
    logic [SCORE_W-1:0]    score_hit;

    function automatic logic [XW-1:0] abs_diff(input logic [XW-1:0] a, input logic [XW-1:0] b);
        return (a >= b) ? a - b : b - a;
    endfunction

    assign press    = i_btn & ~btn_d;
    assign q_scroll = (state == ST_RELD) && (x0 != '0) && (&presc);
    assign q_fill   = (state == ST_RELD) && (x0 == '0) && !all_en;
    assign q_shift  = (state == ST_SHIFT);
    assign q_init   = (state == ST_OVER) && press;

    jump_block_queue #(
        .XW             (XW),
        .NUM_BLOCKS     (NUM_BLOCKS),
        .NUM_TYPES      (NUM_TYPES),
        .MIN_GAP        (MIN_GAP),
        .RAND_W         (RAND_W),
        .ORIGIN_STARTUP (ORIGIN_STARTUP)
    ) u_queue (
        .clk        (clk_machine),
        .rst        (rst_machine),
        .init       (q_init),
        .scroll     (q_scroll),
        .fill       (q_fill),
        .shift      (q_shift),
        .random     (i_random),
        .x_block    (o_x_block),
        .type_index (o_type_index),
        .en_block   (o_en_block),
        .x0         (x0),
        .x1         (x1),
        .all_en     (all_en),
        .fill_last  (fill_last)
    );

    // The WAIT->ACCU edge already counts as the first charge cycle.
    always_comb begin
        acc_nxt = acc;
        if (((state == ST_WAIT) || (state == ST_ACCU)) && i_btn && !(&acc))
            acc_nxt = acc + ACC_W'(1);
        else if ((state == ST_JUMP) && jmp.i_jump_done)
            acc_nxt = '0;
    end

    assign d0     = abs_diff(o_x_man, x0);
    assign d1     = abs_diff(o_x_man, x1);
    assign centre = (d1 <= XW'(CENTER_TOL));

`ifdef JUMP_COMBO_EN
    logic [3:0] combo;
    logic [3:0] combo_inc;

    assign combo_inc = (combo == 4'hF) ? combo : combo + 4'd1;

    always_comb begin
        hit_pts = 5'd1;
        if (centre)
            hit_pts = {combo_inc, 1'b0};
    end

    always_ff @(posedge clk_machine) begin
        if (rst_machine || (state == ST_OVER))
            combo <= '0;
        else if ((state == ST_LAND) && (d0 > XW'(HALF_WIDTH)) && (d1 <= XW'(HALF_WIDTH)))
            combo <= centre ? combo_inc : 4'd0;
    end
`else
    always_comb begin
        hit_pts = 5'd1;
        if (centre)
            hit_pts = 5'd2;
    end
`endif

    assign score_sum = {1'b0, o_score} + (SCORE_W+1)'(hit_pts);
    assign score_hit = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    assign o_state   = state;

    always_ff @(posedge clk_machine) begin
        if (rst_machine) begin
            state             <= ST_TITLE;
            btn_d             <= 1'b1;
            presc             <= '0;
            acc               <= '0;
            jmp.o_jump_en     <= 1'b0;
            jmp.o_jump_v_init <= '0;
            o_squeeze_man     <= '0;
            o_x_man           <= XW'(ORIGIN_STARTUP);
            o_y_man           <= '0;
            o_score           <= '0;
            o_title           <= 1'b1;
            o_gameover        <= 1'b0;
        end else begin
            btn_d             <= i_btn;
            acc               <= acc_nxt;
            jmp.o_jump_v_init <= acc_nxt[ACC_W-1 -: VW];
            o_squeeze_man     <= (acc_nxt[ACC_W-1 -: 4] > 4'd14) ? 4'd14 : acc_nxt[ACC_W-1 -: 4];
            presc             <= (state == ST_RELD) ? presc + 1'b1 : '0;

            case (state)
                ST_TITLE: begin
                    if (press) begin
                        state   <= ST_RELD;
                        o_title <= 1'b0;
                    end
                end
                ST_RELD: begin
                    o_x_man <= x0;
                    o_y_man <= '0;
                    if ((x0 == '0) && (all_en || fill_last))
                        state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_btn)
                        state <= ST_ACCU;
                end
                ST_ACCU: begin
                    if (!i_btn) begin
                        state         <= ST_JUMP;
                        jmp.o_jump_en <= 1'b1;
                    end
                end
                ST_JUMP: begin
                    o_x_man <= x0 + jmp.i_jump_dist;
                    o_y_man <= jmp.i_jump_height;
                    if (jmp.i_jump_done) begin
                        state         <= ST_LAND;
                        jmp.o_jump_en <= 1'b0;
                    end
                end
                ST_LAND: begin
                    if (d0 <= XW'(HALF_WIDTH)) begin
                        state <= ST_WAIT;
                    end else if (d1 <= XW'(HALF_WIDTH)) begin
                        state   <= ST_SHIFT;
                        o_score <= score_hit;
                    end else begin
                        state      <= ST_OVER;
                        o_gameover <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    o_x_man <= x1;
                    o_y_man <= '0;
                    state   <= ST_RELD;
                end
                ST_OVER: begin
                    if (press) begin
                        state      <= ST_TITLE;
                        o_score    <= '0;
                        o_gameover <= 1'b0;
                        o_title    <= 1'b1;
                        o_x_man    <= XW'(ORIGIN_STARTUP);
                        o_y_man    <= '0;
                    end
                end
                default: state <= ST_TITLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jump_game_ctrl.sv
// Directed bench for jump_game_ctrl with a short prescaler and narrow accumulator.
module tb_jump_game_ctrl;
    localparam int XW  = 11;
    localparam int NB  = 3;
    localparam int VW  = 7;
    localparam int ACC = 10;
    localparam int RD  = 2;

`ifdef JUMP_COMBO_EN
    localparam int EXP_HIT2 = 6;
    localparam int EXP_HIT3 = 12;
`else
    localparam int EXP_HIT2 = 4;
    localparam int EXP_HIT3 = 6;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          btn;
    logic [6:0]    rnd;
    logic [3:0]    squeeze;
    logic [2:0]    state;
    logic [XW-1:0] x_man;
    logic [8:0]    y_man;
    logic [NB*XW-1:0] x_block;
    logic [NB*5-1:0]  type_index;
    logic [NB-1:0]    en_block;
    logic [15:0]   score;
    logic          title;
    logic          gameover;

    int checks = 0;
    int errors = 0;

    jump_game_ctrl_if #(.XW(XW), .VW(VW)) jmp ();

    jump_game_ctrl #(
        .ACC_W      (ACC),
        .RELOAD_DIV (RD)
    ) dut (
        .clk_machine   (clk),
        .rst_machine   (rst),
        .i_btn         (btn),
        .i_random      (rnd),
        .jmp           (jmp),
        .o_squeeze_man (squeeze),
        .o_state       (state),
        .o_x_man       (x_man),
        .o_y_man       (y_man),
        .o_x_block     (x_block),
        .o_type_index  (type_index),
        .o_en_block    (en_block),
        .o_score       (score),
        .o_title       (title),
        .o_gameover    (gameover)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int slot_x(input int k);
        return int'(x_block[k*XW +: XW]);
    endfunction

    task automatic wait_state(input logic [2:0] target, input int limit, output int n);
        n = 0;
        while ((state != target) && (n < limit)) begin
            tick(1);
            n++;
        end
    endtask

    task automatic check_field(input string tag);
        chk({tag, "_s0"}, slot_x(0), 0);
        chk({tag, "_s1"}, slot_x(1), 75);
        chk({tag, "_s2"}, slot_x(2), 150);
        chk({tag, "_en"}, en_block, 3'b111);
    endtask

    task automatic jump(input string tag, input int d, input int hold);
        int a;
        a = (hold > 1023) ? 1023 : hold;
        btn = 1'b1;
        tick(hold);
        chk({tag, "_vinit"}, jmp.o_jump_v_init, a >> 3);
        chk({tag, "_squeeze"}, squeeze, ((a >> 6) > 14) ? 14 : (a >> 6));
        btn = 1'b0;
        tick(1);
        chk({tag, "_st_jump"}, state, 4);
        chk({tag, "_en_rise"}, jmp.o_jump_en, 1);
        jmp.i_jump_dist   = XW'(d);
        jmp.i_jump_height = 9'd37;
        tick(3);
        chk({tag, "_en_hold"}, jmp.o_jump_en, 1);
        chk({tag, "_man_x"}, x_man, d);
        chk({tag, "_man_y"}, y_man, 37);
        jmp.i_jump_done = 1'b1;
        tick(1);
        jmp.i_jump_done = 1'b0;
        chk({tag, "_st_land"}, state, 5);
        chk({tag, "_en_fall"}, jmp.o_jump_en, 0);
        chk({tag, "_vclr"}, jmp.o_jump_v_init, 0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        btn = 1'b0;
        rnd = 7'd10;
        jmp.i_jump_done   = 1'b0;
        jmp.i_jump_dist   = '0;
        jmp.i_jump_height = '0;
        tick(3);
        rst = 1'b0;

        chk("rst_state", state, 0);
        chk("rst_title", title, 1);
        chk("rst_over", gameover, 0);
        chk("rst_score", score, 0);
        chk("rst_s0", slot_x(0), 100);
        chk("rst_en", en_block, 3'b001);
        chk("rst_types", type_index, (2 << 10) | (1 << 5));
        chk("rst_manx", x_man, 100);
        chk("rst_jen", jmp.o_jump_en, 0);
        tick(2);

        btn = 1'b1;
        tick(1);
        btn = 1'b0;
        chk("press_title", title, 0);
        chk("press_state", state, 1);
        wait_state(3'd2, 1000, n);
        chk("reld_cycles", n, 402);
        check_field("fill1");
        chk("fill1_manx", x_man, 0);

        jmp.i_jump_done = 1'b1;
        tick(1);
        jmp.i_jump_done = 1'b0;
        chk("done_ignored", state, 2);

        jump("j1", 75, 8);
        tick(1);
        chk("j1_shift", state, 6);
        chk("j1_score", score, 2);
        tick(1);
        chk("j1_reld", state, 1);
        chk("j1_s0", slot_x(0), 75);
        chk("j1_manx", x_man, 75);
        chk("j1_en", en_block, 3'b011);
        chk("j1_types", type_index, (3 << 10) | (2 << 5) | 1);
        wait_state(3'd2, 1000, n);
        check_field("fill2");

        jump("j2", 100, 8);
        tick(1);
        chk("j2_shift", state, 6);
        chk("j2_score", score, 3);
        wait_state(3'd2, 1000, n);
        check_field("fill3");

        jump("j3", 20, 20);
        tick(1);
        chk("j3_wait", state, 2);
        chk("j3_score", score, 3);

        jump("j4", 200, 1100);
        tick(1);
        chk("j4_over", state, 7);
        chk("j4_gameover", gameover, 1);

        btn = 1'b1;
        tick(1);
        chk("over_state", state, 0);
        chk("over_gameover", gameover, 0);
        chk("over_title", title, 1);
        chk("over_score", score, 0);
        chk("over_s0", slot_x(0), 100);
        chk("over_en", en_block, 3'b001);
        tick(2);
        chk("held_no_press", state, 0);
        btn = 1'b0;
        tick(1);

        btn = 1'b1;
        tick(1);
        btn = 1'b0;
        wait_state(3'd2, 1000, n);
        check_field("g2_fill");

        jump("c1", 75, 8);
        tick(1);
        chk("c1_score", score, 2);
        wait_state(3'd2, 1000, n);
        jump("c2", 75, 8);
        tick(1);
        chk("c2_score", score, EXP_HIT2);
        wait_state(3'd2, 1000, n);
        jump("c3", 75, 8);
        tick(1);
        chk("c3_score", score, EXP_HIT3);
        wait_state(3'd2, 1000, n);
        check_field("c3_fill");

        btn = 1'b1;
        tick(8);
        btn = 1'b0;
        tick(1);
        jmp.i_jump_dist = XW'(50);
        tick(2);
        chk("mid_jen", jmp.o_jump_en, 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mrst_jen", jmp.o_jump_en, 0);
        chk("mrst_state", state, 0);
        chk("mrst_score", score, 0);
        chk("mrst_s0", slot_x(0), 100);
        chk("mrst_title", title, 1);
        chk("mrst_manx", x_man, 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
